// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: segment width,
// logical hex decode table and the logical "all segments off" value.
package seg_pkg;

  localparam int unsigned SEG_W = 7;

  // Logical off pattern (bit = 1 means lit).
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Hex to {g,f,e,d,c,b,a}, logical polarity.
  localparam logic [SEG_W-1:0] SEG_DECODE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational hex nibble to logical seven-segment pattern.
module seven_segment_decoder
  import seg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] segments
);

  // Table lookup of the logical segment pattern.
  always_comb begin
    segments = SEG_DECODE[nibble];
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed N-digit seven-segment driver with guard cycle,
// frame-synchronous display update and configurable pin polarity.
// Optional blink support is built when SEG_BLINK_EN is defined.
module seven_segment_scanner
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned PRESCALE       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1,
  parameter int unsigned BLINK_FRAMES   = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [SEG_W-1:0]        seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = $clog2(PRESCALE);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SEG_W-1:0] SEG_OFF = SEG_ACTIVE_LOW ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? '1 : '0;

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] pend_data;
  logic [NUM_DIGITS-1:0]   pend_blank;
  logic                    pend_v;
  logic [4*NUM_DIGITS-1:0] disp_data;
  logic [NUM_DIGITS-1:0]   disp_blank;

  logic                    slot_end;
  logic                    boundary;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   dig_l;
  logic                    blank_sel;
  logic                    blink_sel;
  logic                    suppress;
  logic [SEG_W-1:0]        dec_seg;
  logic [SEG_W-1:0]        seg_l;

  assign slot_end = (cnt == CNT_LAST);
  assign boundary = slot_end && (idx == IDX_LAST);

  // Prescaler and digit index scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Pending/display double buffer; a load on the boundary bypasses pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data  <= '0;
      pend_blank <= '0;
      pend_v     <= 1'b0;
      disp_data  <= '0;
      disp_blank <= '0;
    end else if (boundary) begin
      pend_v <= 1'b0;
      if (load) begin
        disp_data  <= digit_data;
        disp_blank <= blank_mask;
      end else if (pend_v) begin
        disp_data  <= pend_data;
        disp_blank <= pend_blank;
      end
    end else if (load) begin
      pend_data  <= digit_data;
      pend_blank <= blank_mask;
      pend_v     <= 1'b1;
    end
  end

  // Select nibble, blank bit, blink bit and logical enable of digit idx.
  always_comb begin
    nib       = '0;
    dig_l     = '0;
    blank_sel = 1'b0;
    blink_sel = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        nib       = disp_data[4*k +: 4];
        dig_l[k]  = 1'b1;
        blank_sel = disp_blank[k];
        blink_sel = blink_mask[k];
      end
    end
  end

`ifdef SEG_BLINK_EN
  localparam int unsigned FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

  logic [FR_W-1:0] frame_cnt;
  logic            blink_phase;

  // Frame counter; blink phase flips each time it wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (boundary) begin
      if (frame_cnt == FR_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign suppress = blink_phase & blink_sel;
`else
  logic unused_blink;
  assign unused_blink = blink_sel ^ (BLINK_FRAMES == 0);
  assign suppress     = 1'b0;
`endif

  seven_segment_decoder u_decoder (
    .nibble   (nib),
    .segments (dec_seg)
  );

  assign seg_l = (blank_sel || suppress) ? SEG_BLANK : dec_seg;

  // Registered pins: guard slot at cnt==0, else selected digit, physical polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= SEG_OFF;
      dig_sel    <= DIG_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (cnt == '0) begin
        seg_out <= SEG_OFF;
        dig_sel <= DIG_OFF;
      end else begin
        seg_out <= seg_l ^ {SEG_W{SEG_ACTIVE_LOW}};
        dig_sel <= dig_l ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner (4 digits, prescale 4,
// active-low pins). Blink checks apply when SEG_BLINK_EN is defined.
module tb_seven_segment_scanner;

  typedef struct {
    logic [15:0] exp_data;
    logic [3:0]  exp_blank;
    int          ld1_k;
    logic [15:0] ld1_data;
    logic [3:0]  ld1_blank;
    int          ld2_k;
    logic [15:0] ld2_data;
    logic [3:0]  ld2_blank;
  } frame_vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digit_data = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic [6:0]  seg_out;
  logic [3:0]  dig_sel;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  frame_vec_t vecs [4];
  frame_vec_t bvecs [4];

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .NUM_DIGITS     (4),
    .PRESCALE       (4),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1),
    .BLINK_FRAMES   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .digit_data (digit_data),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .seg_out    (seg_out),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );

  function automatic logic [6:0] ref_dec(input logic [3:0] n);
    case (n)
      4'h0: ref_dec = 7'h3F;  4'h1: ref_dec = 7'h06;
      4'h2: ref_dec = 7'h5B;  4'h3: ref_dec = 7'h4F;
      4'h4: ref_dec = 7'h66;  4'h5: ref_dec = 7'h6D;
      4'h6: ref_dec = 7'h7D;  4'h7: ref_dec = 7'h07;
      4'h8: ref_dec = 7'h7F;  4'h9: ref_dec = 7'h6F;
      4'hA: ref_dec = 7'h77;  4'hB: ref_dec = 7'h7C;
      4'hC: ref_dec = 7'h39;  4'hD: ref_dec = 7'h5E;
      4'hE: ref_dec = 7'h79;  default: ref_dec = 7'h71;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_off(input string name);
    chk({name, " seg"}, {1'b0, seg_out}, 8'h7F);
    chk({name, " dig"}, {4'b0, dig_sel}, 8'h0F);
    chk({name, " fd"}, {7'b0, frame_done}, 8'h00);
  endtask

  // Checks the 16 samples of one frame; starts just after a frame_done sample.
  task automatic check_frame(input frame_vec_t v, input string tag);
    int          d;
    int          c;
    logic [3:0]  exp_dig;
    logic [6:0]  exp_seg;
    logic [3:0]  nib;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      d = k / 4;
      c = k % 4;
      if (c == 0) begin
        exp_dig = 4'hF;
        exp_seg = 7'h7F;
      end else begin
        exp_dig = 4'(~(4'b0001 << d));
        nib     = v.exp_data[d*4 +: 4];
        exp_seg = v.exp_blank[d] ? 7'h7F : ~ref_dec(nib);
      end
      chk($sformatf("%s s%0d dig", tag, k), {4'b0, dig_sel}, {4'b0, exp_dig});
      chk($sformatf("%s s%0d seg", tag, k), {1'b0, seg_out}, {1'b0, exp_seg});
      chk($sformatf("%s s%0d fd", tag, k), {7'b0, frame_done}, {7'b0, (k == 15)});
      if (k == v.ld1_k) begin
        load = 1'b1; digit_data = v.ld1_data; blank_mask = v.ld1_blank;
      end else if (k == v.ld2_k) begin
        load = 1'b1; digit_data = v.ld2_data; blank_mask = v.ld2_blank;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 40);
    chk({name, " frame_done seen"}, {7'b0, frame_done}, 8'h01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0000, 4'b0000,  3, 16'h1A2F, 4'b0000, -1, 16'h0000, 4'b0000};
    vecs[1] = '{16'h1A2F, 4'b0000,  2, 16'h1234, 4'b0000,  9, 16'h5678, 4'b0000};
    vecs[2] = '{16'h5678, 4'b0000, 14, 16'h9ABC, 4'b0100, -1, 16'h0000, 4'b0000};
    vecs[3] = '{16'h9ABC, 4'b0100, -1, 16'h0000, 4'b0000, -1, 16'h0000, 4'b0000};

    bvecs[0] = '{16'h0000, 4'b0000, -1, 16'h0000, 4'b0000, -1, 16'h0000, 4'b0000};
`ifdef SEG_BLINK_EN
    bvecs[1] = '{16'h0000, 4'b0001, -1, 16'h0000, 4'b0000, -1, 16'h0000, 4'b0000};
    bvecs[2] = '{16'h0000, 4'b0001, -1, 16'h0000, 4'b0000, -1, 16'h0000, 4'b0000};
`else
    bvecs[1] = '{16'h0000, 4'b0000, -1, 16'h0000, 4'b0000, -1, 16'h0000, 4'b0000};
    bvecs[2] = '{16'h0000, 4'b0000, -1, 16'h0000, 4'b0000, -1, 16'h0000, 4'b0000};
`endif
    bvecs[3] = '{16'h0000, 4'b0000, -1, 16'h0000, 4'b0000, -1, 16'h0000, 4'b0000};

    // Reset held: outputs off.
    @(negedge clk);
    chk_off("reset1");
    @(negedge clk);
    chk_off("reset2");
    rst_n = 1'b1;

    // First cycle after release is a guard, second lights digit 0 with "0".
    @(negedge clk);
    chk_off("post_rst guard");
    @(negedge clk);
    chk("post_rst dig", {4'b0, dig_sel}, 8'h0E);
    chk("post_rst seg", {1'b0, seg_out}, 8'h40);

    wait_frame("first");

    // Loads mid-frame, overwrite, boundary load with blank mask.
    for (int i = 0; i < 4; i++) begin
      check_frame(vecs[i], $sformatf("frame%0d", i));
    end

    // Pending load discarded by an asynchronous reset mid-frame.
    load = 1'b1; digit_data = 16'hDEF7; blank_mask = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_off("async_rst");
    @(negedge clk);
    chk_off("async_rst hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk_off("rerst guard");
    @(negedge clk);
    chk("rerst dig", {4'b0, dig_sel}, 8'h0E);
    chk("rerst seg", {1'b0, seg_out}, 8'h40);
    wait_frame("rerst");

    // Blink on digit 0; frames 1..4 after reset.
    blink_mask = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      check_frame(bvecs[i], $sformatf("blink%0d", i + 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed driver for an N-digit seven-segment display in the security system's operator panel. Latches a packed hex word plus blank mask and scans the digits at a fixed refresh rate with hex-to-segment decode. Segment and digit-enable polarity are configurable. Inserts a ghost-suppression guard cycle between digits and updates the displayed value only at frame boundaries, so the display never tears. Sits between the system controller, which supplies status and code digits, and the board pins.

## Interface
- NUM_DIGITS, 4, digit count; range 1..8.
- PRESCALE, 50000, clk cycles per digit slot; minimum 2.
- SEG_ACTIVE_LOW, 1, 1 = segment pins are driven low to light a segment.
- DIG_ACTIVE_LOW, 1, 1 = digit-enable pins are driven low to enable a digit.
- BLINK_FRAMES, 64, full frames per blink half-period; used only with SEG_BLINK_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  single-cycle strobe; latch digit_data and blank_mask.
- digit_data  in  4*NUM_DIGITS  packed hex nibbles; digit k = [4k+3:4k]; digit 0 is rightmost.
- blank_mask  in  NUM_DIGITS  bit k = 1 blanks digit k.
- blink_mask  in  NUM_DIGITS  bit k = 1 makes digit k blink; sampled live.
- seg_out  out  7  segments {g,f,e,d,c,b,a}, physical polarity.
- dig_sel  out  NUM_DIGITS  one-hot digit enable, physical polarity.
- frame_done  out  1  one-cycle pulse per completed scan frame.

## Operation
- Prescaler cnt runs 0..PRESCALE-1. At the terminal count it wraps to 0 and digit index idx advances, wrapping from NUM_DIGITS-1 to 0.
- Frame boundary = cnt==PRESCALE-1 && idx==NUM_DIGITS-1.
- load=1 copies digit_data/blank_mask into pending regs and sets pend_v. Successive loads overwrite; the last load before the boundary wins.
- At a frame boundary with pend_v=1: display regs <= pending, pend_v <= 0.
- If load coincides with the boundary, the value being loaded that cycle goes straight to the display regs and pend_v stays 0.
- Guard cycle: cnt==0 -> all digits off, segments off. cnt 1..PRESCALE-1 -> dig_sel enables digit idx only.
- Lit pattern = decode(display nibble idx), logically forced to 0 if the digit is blanked (or blink-suppressed).
- Decode (logical, bit=1 lit), hex: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.
- Polarity: seg_out is the logical value when SEG_ACTIVE_LOW=0 and its bitwise inverse when 1. dig_sel follows the same rule with DIG_ACTIVE_LOW.

## Timing
- All outputs are registered. Outputs reflect the cnt/idx state of the previous cycle, so latency is 1 clk.
- Reset values: cnt=0, idx=0, pend_v=0, pending and display regs = 0, frame_done=0.
- Reset value of seg_out: all segments off, i.e. 7'h7F when SEG_ACTIVE_LOW=1, else 0.
- Reset value of dig_sel: all digits off, i.e. all ones when DIG_ACTIVE_LOW=1, else 0.
- First lit cycle after reset release: cycle 2, digit 0 showing "0".
- frame_done is asserted in the cycle after the frame boundary, the same cycle the new display value first takes effect.
- A load takes effect on the pins at most one frame (NUM_DIGITS*PRESCALE cycles) plus 1 cycle later.
- Reset asserted mid-frame: all state clears asynchronously and outputs go to the off value immediately. Pending data is discarded.
- NUM_DIGITS=1: idx is constant 0, every slot end is a frame boundary, and the guard cycle still applies.

## Configuration
- SEG_BLINK_EN defined:
  - Adds a frame counter 0..BLINK_FRAMES-1 and a blink_phase bit.
  - blink_phase toggles on each counter wrap.
  - While blink_phase=1, digits with blink_mask=1 are blanked.
  - Reset: counter=0, blink_phase=0.
- SEG_BLINK_EN undefined:
  - No counter or phase logic is built.
  - blink_mask is ignored and BLINK_FRAMES is unused.

## Structure
- Package seg_pkg:
  - SEG_W=7.
  - Logical decode constant table (16×7).
  - SEG_BLANK = 7'h00 (logical off).
- Sub-module seven_segment_decoder: combinational 4-bit hex to 7-bit logical segments, instantiated once on the selected nibble.
- Polarity inversion and output registers live in the top module.

## Test plan
All scenarios use NUM_DIGITS=4, PRESCALE=4, active-low pins.
1. Reset: hold rst_n=0, then release → seg_out=7F and dig_sel=F throughout reset; first lit cycle shows dig_sel=E, seg_out=~3F=40.
2. Load digit_data=16'h1A2F, pulse → after the next frame boundary, digits 0..3 show ~71, ~5B, ~77, ~06. Each digit is lit 3 cycles, with 1 guard cycle of dig_sel=F between digits.
3. Load 16'h1234 then, mid-frame, 16'h5678 → the current frame is unchanged; the next frame shows 5678 only. frame_done pulses once per 16 cycles.
4. Load with the strobe on the boundary cycle, blank_mask=4'b0100 → the next frame shows the new value, with digit 2 seg_out=7F while dig_sel=B.
5. Assert rst_n=0 mid-frame after a pending load → outputs are off immediately; after release the display shows 0000 and the pending value is lost.
6. With SEG_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0001 → digit 0 is lit for 2 frames and blank for 2 frames, alternating; the other digits are unaffected.
